// File: rtl/tile_pkg.sv
// Shared types and geometry for the tile map controller and its level ROM.
package tile_pkg;

    localparam int MAP_W     = 8;
    localparam int MAP_H     = 8;
    localparam int COORD_W   = 3;
    localparam int MAP_CELLS = MAP_W * MAP_H;
    localparam int INDEX_W   = 6;
    localparam int COUNT_W   = 7;

    typedef enum logic [1:0] {
        TILE_EMPTY = 2'b00,
        TILE_WALL  = 2'b01,
        TILE_COIN  = 2'b10,
        TILE_SPIKE = 2'b11
    } tile_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

    // Row-major flat index of a cell: row (Y) in the upper bits, column (X) in the lower bits.
    function automatic logic [INDEX_W-1:0] cellIndex(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/level_rom.sv
// Combinational store of the four built-in 8x8 levels, addressed row-major.
module level_rom
    import tile_pkg::*;
(
    input  logic [1:0]         level,
    input  logic [INDEX_W-1:0] index,
    output logic [1:0]         tile
);

    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;

    assign row = index[5:3];
    assign col = index[2:0];

    // Each level is described by a few geometric rules rather than a literal table.
    always_comb begin
        tile = TILE_EMPTY;
        case (level)
            2'd0: begin
                if (row == 3'd7 && col <= 3'd5) begin
                    tile = TILE_WALL;
                end else if (row == 3'd2 && col == 3'd3) begin
                    tile = TILE_COIN;
                end
            end
            2'd1: begin
                if (row == 3'd0 || row == 3'd7 || col == 3'd0 || col == 3'd7) begin
                    tile = TILE_WALL;
                end else if (row == 3'd3) begin
                    tile = TILE_COIN;
                end else if (row == 3'd5 && col == 3'd4) begin
                    tile = TILE_SPIKE;
                end
            end
            2'd2: begin
                if (row == col) begin
                    tile = TILE_SPIKE;
                end else if (({1'b0, row} + {1'b0, col}) == 4'd7) begin
                    tile = TILE_WALL;
                end
            end
            default: begin
                tile = TILE_COIN;
            end
        endcase
    end

endmodule

// File: rtl/tile_map_ctrl.sv
// Tile map controller: 8x8 map with VGA read port, arbitrated query/write ports,
// level loader FSM and a running count of coin tiles.
module tile_map_ctrl
    import tile_pkg::*;
(
    input  logic               clk,
    input  logic               resetN,
    input  logic               loadStart,
    input  logic [1:0]         loadLevel,
    output logic               busy,
    input  logic [COORD_W-1:0] drawX,
    input  logic [COORD_W-1:0] drawY,
    output logic [1:0]         drawType,
    input  logic               qReq,
    input  logic [COORD_W-1:0] qX,
    input  logic [COORD_W-1:0] qY,
    output logic               qAck,
    output logic [1:0]         qType,
    input  logic               wReq,
    input  logic [COORD_W-1:0] wX,
    input  logic [COORD_W-1:0] wY,
    input  logic [1:0]         wType,
    output logic               wAck,
    output logic [COUNT_W-1:0] coinsLeft,
    output logic               levelClear
);

    ctrl_state_e        state_q, state_d;
    logic [1:0]         level_q, level_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic [COUNT_W-1:0] coins_q, coins_d;
    logic               favorQ_q, favorQ_d;
    logic               levelClear_q, levelClear_d;
    logic               qAck_q, wAck_q;
    logic [1:0]         qType_q, qType_d;
    logic [1:0]         drawType_q;
    logic [1:0]         map_q [MAP_CELLS];

    logic               qGrant, wGrant;
    logic [1:0]         romTile;
    logic [1:0]         wOld;
    logic               mapWe;
    logic [INDEX_W-1:0] mapWAddr;
    logic [1:0]         mapWData;

    level_rom u_level_rom (
        .level (level_q),
        .index (idx_q),
        .tile  (romTile)
    );

    // One shared access slot: grants only while idle, round-robin when both ask.
    always_comb begin
        qGrant   = (state_q == IDLE) && qReq && (!wReq || favorQ_q);
        wGrant   = (state_q == IDLE) && wReq && (!qReq || !favorQ_q);
        favorQ_d = favorQ_q;
        if (qGrant) begin
            favorQ_d = 1'b0;
        end else if (wGrant) begin
            favorQ_d = 1'b1;
        end
        qType_d = qGrant ? map_q[cellIndex(qX, qY)] : 2'b00;
    end

    // Loader FSM, map write selection and coin bookkeeping.
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        idx_d        = idx_q;
        coins_d      = coins_q;
        levelClear_d = 1'b0;
        mapWe        = 1'b0;
        mapWAddr     = cellIndex(wX, wY);
        mapWData     = wType;
        wOld         = map_q[cellIndex(wX, wY)];
        case (state_q)
            IDLE: begin
                if (wGrant) begin
                    mapWe = 1'b1;
                    if (wOld == TILE_COIN && wType != TILE_COIN && coins_q != '0) begin
                        coins_d      = coins_q - 7'd1;
                        levelClear_d = (coins_q == 7'd1);
                    end else if (wOld != TILE_COIN && wType == TILE_COIN && coins_q != 7'd64) begin
                        coins_d = coins_q + 7'd1;
                    end
                end
                if (loadStart) begin
                    state_d = LOAD;
                    level_d = loadLevel;
                    idx_d   = '0;
                    coins_d = '0;
                end
            end
            LOAD: begin
                mapWe    = 1'b1;
                mapWAddr = idx_q;
                mapWData = romTile;
                if (romTile == TILE_COIN) begin
                    coins_d = coins_q + 7'd1;
                end
                if (idx_q == 6'd63) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            level_q      <= 2'd0;
            idx_q        <= '0;
            coins_q      <= '0;
            favorQ_q     <= 1'b1;
            levelClear_q <= 1'b0;
            qAck_q       <= 1'b0;
            wAck_q       <= 1'b0;
            qType_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            idx_q        <= idx_d;
            coins_q      <= coins_d;
            favorQ_q     <= favorQ_d;
            levelClear_q <= levelClear_d;
            qAck_q       <= qGrant;
            wAck_q       <= wGrant;
            qType_q      <= qType_d;
        end
    end

    // Map storage; the draw port reads the pre-write contents every cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < MAP_CELLS; i++) begin
                map_q[i] <= TILE_EMPTY;
            end
            drawType_q <= 2'b00;
        end else begin
            if (mapWe) begin
                map_q[mapWAddr] <= mapWData;
            end
            drawType_q <= map_q[cellIndex(drawX, drawY)];
        end
    end

    assign busy       = (state_q != IDLE);
    assign drawType   = drawType_q;
    assign qAck       = qAck_q;
    assign qType      = qType_q;
    assign wAck       = wAck_q;
    assign coinsLeft  = coins_q;
    assign levelClear = levelClear_q;

endmodule

// File: tb/tb_tile_map_ctrl.sv
// Bench for tile_map_ctrl: cell-level behavioural model plus directed scenarios.
module tb_tile_map_ctrl;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       loadStart = 1'b0;
    logic [1:0] loadLevel = 2'd0;
    logic       busy;
    logic [2:0] drawX = 3'd0, drawY = 3'd0;
    logic [1:0] drawType;
    logic       qReq = 1'b0;
    logic [2:0] qX = 3'd0, qY = 3'd0;
    logic       qAck;
    logic [1:0] qType;
    logic       wReq = 1'b0;
    logic [2:0] wX = 3'd0, wY = 3'd0;
    logic [1:0] wType = 2'd0;
    logic       wAck;
    logic [6:0] coinsLeft;
    logic       levelClear;

    int testsRun = 0;
    int failures = 0;

    tile_map_ctrl dut (
        .clk        (clk),
        .resetN     (resetN),
        .loadStart  (loadStart),
        .loadLevel  (loadLevel),
        .busy       (busy),
        .drawX      (drawX),
        .drawY      (drawY),
        .drawType   (drawType),
        .qReq       (qReq),
        .qX         (qX),
        .qY         (qY),
        .qAck       (qAck),
        .qType      (qType),
        .wReq       (wReq),
        .wX         (wX),
        .wY         (wY),
        .wType      (wType),
        .wAck       (wAck),
        .coinsLeft  (coinsLeft),
        .levelClear (levelClear)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int mMap [64];
    int mLoadLeft;
    bit mLastW;
    int expDraw, expQType, expCoins;
    bit expBusy, expQAck, expWAck, expClear, drawValid;
    int preLeft, coinsBefore;
    bit gq, gw;

    function automatic int tbLevelTile(input int level, input int row, input int col);
        case (level)
            0: begin
                if (row == 7 && col <= 5) return 1;
                if (row == 2 && col == 3) return 2;
                return 0;
            end
            1: begin
                if (row == 0 || row == 7 || col == 0 || col == 7) return 1;
                if (row == 3) return 2;
                if (row == 5 && col == 4) return 3;
                return 0;
            end
            2: begin
                if (row == col) return 3;
                if (row + col == 7) return 1;
                return 0;
            end
            default: return 2;
        endcase
    endfunction

    function automatic int cellOf(input logic [2:0] x, input logic [2:0] y);
        return int'(y) * 8 + int'(x);
    endfunction

    function automatic int countCoins();
        int n = 0;
        for (int i = 0; i < 64; i++) if (mMap[i] == 2) n++;
        return n;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 64; i++) mMap[i] = 0;
        mLoadLeft = 0;
        mLastW    = 1'b1;
        expDraw   = 0;
        expQType  = 0;
        expCoins  = 0;
        expBusy   = 1'b0;
        expQAck   = 1'b0;
        expWAck   = 1'b0;
        expClear  = 1'b0;
        drawValid = 1'b1;
    endtask

    // Model advances one cycle per clock edge from the sampled inputs.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            modelReset();
        end else begin
            preLeft   = mLoadLeft;
            drawValid = (preLeft <= 1);
            expDraw   = mMap[cellOf(drawX, drawY)];
            gq = 1'b0;
            gw = 1'b0;
            if (preLeft == 0) begin
                if (qReq && wReq) begin
                    if (mLastW) gq = 1'b1; else gw = 1'b1;
                end else begin
                    gq = qReq;
                    gw = wReq;
                end
            end
            expQAck  = gq;
            expWAck  = gw;
            expQType = gq ? mMap[cellOf(qX, qY)] : 0;
            if (gq) mLastW = 1'b0;
            if (gw) mLastW = 1'b1;
            expClear = 1'b0;
            if (gw) begin
                coinsBefore = countCoins();
                mMap[cellOf(wX, wY)] = int'(wType);
                if (coinsBefore == 1 && countCoins() == 0) expClear = 1'b1;
            end
            if (preLeft > 0) begin
                mLoadLeft = preLeft - 1;
            end else if (loadStart) begin
                mLoadLeft = 65;
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        mMap[r * 8 + c] = tbLevelTile(int'(loadLevel), r, c);
            end
            expBusy  = (mLoadLeft > 0);
            expCoins = countCoins();
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Compare DUT against the model on the falling edge, where outputs are settled.
    always @(negedge clk) begin
        if (resetN) begin
            checkOutput("busy", busy, expBusy);
            checkOutput("qAck", qAck, expQAck);
            checkOutput("wAck", wAck, expWAck);
            checkOutput("levelClear", levelClear, expClear);
            if (expQAck) checkOutput("qType", qType, expQType);
            if (drawValid) checkOutput("drawType", drawType, expDraw);
            if (!expBusy) checkOutput("coinsLeft", coinsLeft, expCoins);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic q, input logic [2:0] qx, input logic [2:0] qy,
                                 input logic w, input logic [2:0] wx, input logic [2:0] wy,
                                 input logic [1:0] wt);
        qReq  = q;
        qX    = qx;
        qY    = qy;
        wReq  = w;
        wX    = wx;
        wY    = wy;
        wType = wt;
    endtask

    task automatic startLoad(input logic [1:0] lvl);
        loadLevel = lvl;
        loadStart = 1'b1;
        tick();
        loadStart = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        for (int k = 0; k < 200 && busy; k++) tick();
        checkOutput(name, busy, 0);
    endtask

    task automatic writeCell(input logic [2:0] x, input logic [2:0] y, input logic [1:0] t);
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b1, x, y, t);
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 2'd0);
    endtask

    int cnt;
    int seq [4];

    initial begin
        // Reset state
        resetN = 1'b0;
        repeat (3) tick();
        checkOutput("reset busy", busy, 0);
        checkOutput("reset drawType", drawType, 0);
        checkOutput("reset qAck", qAck, 0);
        checkOutput("reset wAck", wAck, 0);
        checkOutput("reset qType", qType, 0);
        checkOutput("reset coinsLeft", coinsLeft, 0);
        checkOutput("reset levelClear", levelClear, 0);
        resetN = 1'b1;
        tick();

        // Level 0 load: 65 busy cycles, one coin, wall at row 7
        startLoad(2'd0);
        cnt = busy ? 1 : 0;
        for (int k = 0; k < 200 && busy; k++) begin
            tick();
            if (busy) cnt++;
        end
        checkOutput("load0 busy cycles", cnt, 65);
        checkOutput("load0 finished", busy, 0);
        drawX = 3'd5;
        drawY = 3'd7;
        tick();
        checkOutput("load0 draw(5,7)", drawType, 1);
        checkOutput("load0 coins", coinsLeft, 1);

        // Both ports held: grants alternate starting with query
        applyStimulus(1'b1, 3'd3, 3'd2, 1'b1, 3'd0, 3'd0, 2'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            seq[k] = int'(qAck) * 2 + int'(wAck);
            if (k == 0) checkOutput("rr first qType", qType, 2);
        end
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 2'd0);
        checkOutput("rr grant 0", seq[0], 2);
        checkOutput("rr grant 1", seq[1], 1);
        checkOutput("rr grant 2", seq[2], 2);
        checkOutput("rr grant 3", seq[3], 1);
        tick();

        // Clearing the last coin pulses levelClear; query sees the new value
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b1, 3'd3, 3'd2, 2'd0);
        tick();
        checkOutput("clear wAck", wAck, 1);
        checkOutput("clear coins", coinsLeft, 0);
        checkOutput("clear pulse", levelClear, 1);
        applyStimulus(1'b1, 3'd3, 3'd2, 1'b0, 3'd0, 3'd0, 2'd0);
        tick();
        checkOutput("clear pulse ends", levelClear, 0);
        checkOutput("post-clear qAck", qAck, 1);
        checkOutput("post-clear qType", qType, 0);
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 2'd0);
        tick();

        // Query held across a level 1 load waits until the FSM is idle again
        startLoad(2'd1);
        applyStimulus(1'b1, 3'd1, 3'd3, 1'b0, 3'd0, 3'd0, 2'd0);
        cnt = 0;
        for (int k = 0; k < 200 && !qAck; k++) begin
            tick();
            cnt++;
        end
        checkOutput("held query latency", cnt, 66);
        checkOutput("held query qType", qType, 2);
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 2'd0);
        tick();
        checkOutput("load1 coins", coinsLeft, 6);

        // loadStart during a load is ignored; zero-coin load gives no levelClear
        startLoad(2'd2);
        repeat (10) tick();
        startLoad(2'd3);
        loadLevel = 2'd0;
        waitIdle("load2 finished");
        drawX = 3'd4;
        drawY = 3'd4;
        tick();
        checkOutput("load2 draw(4,4)", drawType, 3);
        checkOutput("load2 coins", coinsLeft, 0);

        // Reset mid-load aborts and leaves an empty map
        startLoad(2'd3);
        repeat (20) tick();
        resetN = 1'b0;
        #2;
        checkOutput("abort busy", busy, 0);
        checkOutput("abort coins", coinsLeft, 0);
        tick();
        tick();
        resetN = 1'b1;
        drawX = 3'd3;
        drawY = 3'd3;
        repeat (3) tick();
        checkOutput("abort draw(3,3)", drawType, 0);
        checkOutput("abort no reload", busy, 0);

        // Full-coin level and the coin-count write rules at the 64 boundary
        startLoad(2'd3);
        waitIdle("load3 finished");
        checkOutput("load3 coins", coinsLeft, 64);
        writeCell(3'd0, 3'd0, 2'd2);
        checkOutput("coin over coin", coinsLeft, 64);
        writeCell(3'd0, 3'd0, 2'd1);
        checkOutput("wall over coin", coinsLeft, 63);
        writeCell(3'd0, 3'd0, 2'd1);
        checkOutput("wall over wall", coinsLeft, 63);
        checkOutput("wall over wall no clear", levelClear, 0);
        writeCell(3'd0, 3'd0, 2'd2);
        checkOutput("coin over wall", coinsLeft, 64);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
